// File: rtl/display_update_scheduler.sv
// Round-robin two-way update arbiter for the 4-character multiplexed display:
// writes one granted 16-bit word as four nibble loads, then holds off for a scan window.
module display_update_scheduler #(
  parameter int MIN_SCAN_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_a,
  input  logic [15:0] word_a,
  input  logic        req_b,
  input  logic [15:0] word_b,
  output logic        ack_a,
  output logic        ack_b,
  output logic        load,
  output logic [1:0]  char_position,
  output logic [3:0]  data,
  output logic        busy
);
  localparam int SCW = $clog2(MIN_SCAN_CYCLES + 1);
  localparam logic [1:0] S_IDLE = 2'd0, S_LOAD = 2'd1, S_SCAN = 2'd2;

  logic [1:0]     state_q, state_d;
  logic [15:0]    word_q, word_d;
  logic [1:0]     slot_q, slot_d;
  logic [SCW-1:0] scan_cnt_q, scan_cnt_d;
  logic           last_grant_q, last_grant_d;
  logic           ack_a_q, ack_a_d, ack_b_q, ack_b_d;
  logic           load_q, load_d, busy_q, busy_d;
  logic [1:0]     char_q, char_d;
  logic [3:0]     data_q, data_d;
  logic           grant_b;

  always_comb begin
    state_d      = state_q;
    word_d       = word_q;
    slot_d       = slot_q;
    scan_cnt_d   = scan_cnt_q;
    last_grant_d = last_grant_q;
    ack_a_d      = 1'b0;
    ack_b_d      = 1'b0;
    load_d       = load_q;
    busy_d       = busy_q;
    char_d       = char_q;
    data_d       = data_q;
    grant_b      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_a || req_b) begin
          // On a tie the requester that did not win last time goes next.
          grant_b      = (req_a && req_b) ? ~last_grant_q : req_b;
          word_d       = grant_b ? word_b : word_a;
          last_grant_d = grant_b;
          ack_a_d      = ~grant_b;
          ack_b_d      = grant_b;
          slot_d       = 2'd0;
          state_d      = S_LOAD;
          load_d       = 1'b1;
          busy_d       = 1'b1;
          char_d       = 2'd0;
          data_d       = word_d[3:0];
        end
      end
      S_LOAD: begin
        if (slot_q == 2'd3) begin
          state_d    = S_SCAN;
          load_d     = 1'b0;
          scan_cnt_d = SCW'(MIN_SCAN_CYCLES - 1);
        end else begin
          slot_d = slot_q + 2'd1;
          char_d = slot_d;
          data_d = word_q[{slot_d, 2'b00} +: 4];
        end
      end
      S_SCAN: begin
        if (scan_cnt_q == '0) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          scan_cnt_d = scan_cnt_q - SCW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        load_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      word_q       <= '0;
      slot_q       <= '0;
      scan_cnt_q   <= '0;
      last_grant_q <= 1'b1;
      ack_a_q      <= 1'b0;
      ack_b_q      <= 1'b0;
      load_q       <= 1'b0;
      busy_q       <= 1'b0;
      char_q       <= '0;
      data_q       <= '0;
    end else begin
      state_q      <= state_d;
      word_q       <= word_d;
      slot_q       <= slot_d;
      scan_cnt_q   <= scan_cnt_d;
      last_grant_q <= last_grant_d;
      ack_a_q      <= ack_a_d;
      ack_b_q      <= ack_b_d;
      load_q       <= load_d;
      busy_q       <= busy_d;
      char_q       <= char_d;
      data_q       <= data_d;
    end
  end

  assign ack_a         = ack_a_q;
  assign ack_b         = ack_b_q;
  assign load          = load_q;
  assign busy          = busy_q;
  assign char_position = char_q;
  assign data          = data_q;
endmodule

// File: tb/tb_display_update_scheduler.sv
// Scoreboard bench: a timing-level model predicts grants; a monitor checks acks, loads and busy.
module tb_display_update_scheduler;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic req_a = 1'b0, req_b = 1'b0;
  logic [15:0] word_a = '0, word_b = '0;
  logic sel = 1'b0;  // 0: default-scan DUT checked, 1: MIN_SCAN_CYCLES=1 DUT checked

  logic ack_a0, ack_b0, load0, busy0, ack_a1, ack_b1, load1, busy1;
  logic [1:0] cp0, cp1;
  logic [3:0] d0, d1;

  always #5 clk = ~clk;

  display_update_scheduler dut (
    .clk(clk), .reset(reset), .req_a(req_a), .word_a(word_a), .req_b(req_b), .word_b(word_b),
    .ack_a(ack_a0), .ack_b(ack_b0), .load(load0), .char_position(cp0), .data(d0), .busy(busy0));

  display_update_scheduler #(.MIN_SCAN_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .req_a(req_a), .word_a(word_a), .req_b(req_b), .word_b(word_b),
    .ack_a(ack_a1), .ack_b(ack_b1), .load(load1), .char_position(cp1), .data(d1), .busy(busy1));

  wire       o_ack_a = sel ? ack_a1 : ack_a0;
  wire       o_ack_b = sel ? ack_b1 : ack_b0;
  wire       o_load  = sel ? load1 : load0;
  wire       o_busy  = sel ? busy1 : busy0;
  wire [1:0] o_cp    = sel ? cp1 : cp0;
  wire [3:0] o_data  = sel ? d1 : d0;

  typedef struct { logic b; logic [15:0] w; int e; } exp_t;
  exp_t sbq[$];
  int n_chk = 0, n_fail = 0;
  int edge_n = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, expv, edge_n);
    end
  endtask

  // Reference: an update occupies 5+M edges; a grant may happen at any edge once free.
  int  idle_from = 0;
  logic m_last = 1'b1;
  always @(posedge clk) begin
    int m;
    logic g;
    m = sel ? 1 : 16;
    if (!reset) begin
      m_last = 1'b1;
      idle_from = 0;
    end else if (edge_n >= idle_from && (req_a || req_b)) begin
      g = (req_a && req_b) ? !m_last : req_b;
      m_last = g;
      sbq.push_back('{b: g, w: (g ? word_b : word_a), e: edge_n});
      idle_from = edge_n + 5 + m;
    end
    edge_n = edge_n + 1;
  end

  // Monitor
  logic        active = 1'b0;
  int          start = 0;
  logic [15:0] cw = '0;
  always @(negedge clk) begin
    int le, rel, m;
    exp_t x;
    m = sel ? 1 : 16;
    if (!reset) begin
      sbq.delete();
      active = 1'b0;
      check("reset_outputs", {22'd0, o_ack_a, o_ack_b, o_load, o_busy, o_cp, o_data}, 32'd0);
    end else begin
      le = edge_n - 1;
      if (sbq.size() > 0 && sbq[0].e == le) begin
        x = sbq.pop_front();
        check("ack_a", {31'd0, o_ack_a}, {31'd0, !x.b});
        check("ack_b", {31'd0, o_ack_b}, {31'd0, x.b});
        active = 1'b1;
        start = le;
        cw = x.w;
      end else begin
        check("spurious_ack", {30'd0, o_ack_a, o_ack_b}, 32'd0);
      end
      rel = le - start;
      if (active && rel >= 4 + m) active = 1'b0;
      check("busy", {31'd0, o_busy}, {31'd0, active});
      check("load", {31'd0, o_load}, {31'd0, (active && rel < 4)});
      if (active && rel < 4) begin
        check("char_position", {30'd0, o_cp}, rel);
        check("data", {28'd0, o_data}, {28'd0, 4'((cw >> (4 * rel)) & 16'hF)});
      end
    end
  end

  // Driver
  logic hold_a = 1'b0, hold_b = 1'b0, rnd = 1'b0;
  task automatic step();
    @(posedge clk);
    #2;
    if (req_a && o_ack_a && !hold_a) req_a = 1'b0;
    if (req_b && o_ack_b && !hold_b) req_b = 1'b0;
    if (rnd) begin
      if (!req_a) begin
        if ($urandom_range(0, 3) == 0) begin
          word_a = 16'($urandom); req_a = 1'b1; hold_a = ($urandom_range(0, 3) == 0);
        end
      end else if ($urandom_range(0, 29) == 0) req_a = 1'b0;
      if (!req_b) begin
        if ($urandom_range(0, 3) == 0) begin
          word_b = 16'($urandom); req_b = 1'b1; hold_b = ($urandom_range(0, 3) == 0);
        end
      end else if ($urandom_range(0, 29) == 0) req_b = 1'b0;
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_ack(input logic which_b, input int limit);
    int k;
    logic got;
    k = 0;
    got = 1'b0;
    while (!got && k < limit) begin
      step();
      got = which_b ? o_ack_b : o_ack_a;
      k++;
    end
    if (!got) check("wait_ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset(input logic s);
    reset = 1'b0;
    req_a = 1'b0; req_b = 1'b0; hold_a = 1'b0; hold_b = 1'b0;
    steps(2);
    sel = s;
    steps(1);
    reset = 1'b1;
  endtask

  initial begin
    // Reset with random inputs, then quiet idle.
    for (int i = 0; i < 5; i++) begin
      step();
      req_a = 1'($urandom); req_b = 1'($urandom);
      word_a = 16'($urandom); word_b = 16'($urandom);
    end
    req_a = 1'b0; req_b = 1'b0;
    step();
    reset = 1'b1;
    steps(30);

    // Single shot from A.
    word_a = 16'hA5C3; req_a = 1'b1;
    steps(30);

    // Simultaneous A and B from reset, each dropped after its ack.
    do_reset(1'b0);
    word_a = 16'h1234; word_b = 16'hBEEF; req_a = 1'b1; req_b = 1'b1;
    steps(50);

    // Both held continuously for six grants.
    hold_a = 1'b1; hold_b = 1'b1; req_a = 1'b1; req_b = 1'b1;
    steps(6 * 21 - 2);
    hold_a = 1'b0; hold_b = 1'b0; req_a = 1'b0; req_b = 1'b0;
    steps(30);

    // Reset during the second load cycle, then B alone, then a tie.
    word_a = 16'h5A5A; req_a = 1'b1;
    wait_ack(1'b0, 40);
    step();
    reset = 1'b0;
    req_a = 1'b0;
    word_b = 16'($urandom); req_b = 1'b1; hold_b = 1'b1;
    steps(2);
    reset = 1'b1;
    wait_ack(1'b1, 10);
    word_a = 16'($urandom); req_a = 1'b1;
    steps(50);
    hold_b = 1'b0; req_a = 1'b0; req_b = 1'b0;
    steps(25);

    // Minimum scan window: held A, then dropped during SCAN.
    do_reset(1'b1);
    word_a = 16'($urandom); req_a = 1'b1; hold_a = 1'b1;
    wait_ack(1'b0, 10);
    wait_ack(1'b0, 10);
    wait_ack(1'b0, 10);
    steps(4);
    hold_a = 1'b0; req_a = 1'b0;
    steps(15);

    // Randomized traffic on the default-scan DUT.
    do_reset(1'b0);
    rnd = 1'b1;
    steps(600);
    rnd = 1'b0; hold_a = 1'b0; hold_b = 1'b0; req_a = 1'b0; req_b = 1'b0;
    steps(30);
    check("scoreboard_drained", sbq.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
